// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the fetch queue: packet layout, machine width, depth.
package fetch_queue_pkg;

  localparam int unsigned MACHINE_WIDTH    = 3;
  localparam int unsigned FQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        packet_valid;
  } fetch_packet_t;

  // Bits needed to hold a lane count in 0..w.
  function automatic int unsigned lane_cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fq_lane_compact.sv
// Combinational prefix sum over lane valid bits: per-lane write offset and total count.
module fq_lane_compact
  import fetch_queue_pkg::*;
#(
  parameter int unsigned W = MACHINE_WIDTH,
  localparam int unsigned LaneW = lane_cnt_width(W)
) (
  input  logic [W-1:0]            valid,
  output logic [W-1:0][LaneW-1:0] offset,
  output logic [LaneW-1:0]        count
);

  logic [LaneW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < W; i++) begin
      offset[i] = acc;
      acc       = acc + LaneW'(valid[i]);
    end
    count = acc;
  end

endmodule

// File: rtl/fetch_queue.sv
// In-order circular buffer between fetch and decode_rename; compacts input holes,
// dequeues the leading ready lanes, and is cleared by architectural-state recovery.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  fetch_packet_t [MACHINE_WIDTH-1:0]    fetch_pkt,
  output logic [MACHINE_WIDTH-1:0]             fetch_pkt_ready,
  output fetch_packet_t [MACHINE_WIDTH-1:0]    fq_pkt,
  input  logic [MACHINE_WIDTH-1:0]             fq_pkt_ready,
  input  logic                                 recov_arch_st,
  output logic [$clog2(FQ_DEPTH):0]            fq_count
);

  localparam int unsigned W     = MACHINE_WIDTH;
  localparam int unsigned PtrW  = $clog2(FQ_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned LaneW = lane_cnt_width(W);

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  fetch_packet_t mem_q [FQ_DEPTH];

  logic                       space_ok;
  logic                       enq_fire;
  logic [W-1:0]               enq_valid;
  logic [W-1:0]               deq_ok;
  logic [W-1:0]               deq_lead;
  logic                       lead_run;
  logic [W-1:0][LaneW-1:0]    enq_offset;
  logic [W-1:0][LaneW-1:0]    unused_deq_offset;
  logic [LaneW-1:0]           n_enq;
  logic [LaneW-1:0]           n_acc;
  logic [LaneW-1:0]           n_deq;

  // Space check uses only the registered count so fq_pkt_ready never reaches fetch_pkt_ready.
  assign space_ok        = (CntW'(FQ_DEPTH) - count_q) >= CntW'(W);
  assign fetch_pkt_ready = {W{space_ok}};
  assign enq_fire        = space_ok && !recov_arch_st;
  assign fq_count        = count_q;

  always_comb begin
    fq_pkt    = '0;
    deq_ok    = '0;
    deq_lead  = '0;
    enq_valid = '0;
    lead_run  = 1'b1;
    for (int i = 0; i < W; i++) begin
      fq_pkt[i]              = mem_q[head_q + PtrW'(i)];
      fq_pkt[i].packet_valid = (CntW'(i) < count_q) && !recov_arch_st;
      deq_ok[i]              = fq_pkt[i].packet_valid && fq_pkt_ready[i];
      enq_valid[i]           = fetch_pkt[i].packet_valid;
    end
    // Only the unbroken run of ready lanes from lane 0 is consumed.
    for (int i = 0; i < W; i++) begin
      lead_run    = lead_run && deq_ok[i];
      deq_lead[i] = lead_run;
    end
  end

  fq_lane_compact #(
    .W (W)
  ) u_enq_compact (
    .valid  (enq_valid),
    .offset (enq_offset),
    .count  (n_enq)
  );

  fq_lane_compact #(
    .W (W)
  ) u_deq_compact (
    .valid  (deq_lead),
    .offset (unused_deq_offset),
    .count  (n_deq)
  );

  assign n_acc = enq_fire ? n_enq : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (recov_arch_st) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PtrW'(n_deq);
      tail_d  = tail_q + PtrW'(n_acc);
      count_d = count_q + CntW'(n_acc) - CntW'(n_deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is derived from count_q alone.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < W; i++) begin
        if (enq_valid[i]) begin
          mem_q[tail_q + PtrW'(enq_offset[i])] <= fetch_pkt[i];
        end
      end
    end
  end

  count_bounded_a : assert property (@(posedge clk) disable iff (rst)
    count_q <= CntW'(FQ_DEPTH));

  deq_within_count_a : assert property (@(posedge clk) disable iff (rst)
    CntW'(n_deq) <= count_q);

endmodule
